// File: rtl/bus_control_sequencer.sv
// Micro-sequencer for the shared 32-bit datapath bus: fetch (T0-T2) and execute (T3-T6)
// control steps, Moore outputs decoded from the current step and the instruction fields.
module bus_control_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [23:0] bus_src,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned BUS_W = 24;
  localparam int unsigned GPR_N = 16;
  localparam int unsigned SEL_W = 5;

  localparam logic [SEL_W-1:0] SRC_HI  = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO  = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZH  = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZL  = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC  = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR = 5'd21;

  localparam logic [4:0] OP_ALU3_MAX = 5'd5;
  localparam logic [4:0] OP_MUL      = 5'd14;
  localparam logic [4:0] OP_DIV      = 5'd15;
  localparam logic [4:0] OP_MFHI     = 5'd24;
  localparam logic [4:0] OP_MFLO     = 5'd25;
  localparam logic [4:0] OP_NOP      = 5'd26;
  localparam logic [4:0] OP_HALT     = 5'd27;
  localparam logic [4:0] ALU_INC     = 5'b11111;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu3, is_muldiv, is_mfhi, is_mflo, is_nop, is_halt;
  logic       bus_en, reg_en;
  logic [SEL_W-1:0] bus_idx;
  logic       unused_ir_bits;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];
  // low instruction bits carry no field the sequencer decodes
  assign unused_ir_bits = ^ir[14:0];

  assign is_alu3   = (op <= OP_ALU3_MAX);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_mfhi   = (op == OP_MFHI);
  assign is_mflo   = (op == OP_MFLO);
  assign is_nop    = (op == OP_NOP);
  assign is_halt   = (op == OP_HALT);

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state and Moore output decode
  always_comb begin
    state_d = state_q;
    bus_en  = 1'b0;
    bus_idx = '0;
    reg_en  = 1'b0;
    pc_in   = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    illegal = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        bus_en  = 1'b1;
        bus_idx = SRC_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        alu_op  = ALU_INC;
        state_d = S_T1;
      end
      S_T1: begin
        bus_en  = 1'b1;
        bus_idx = SRC_ZL;
        pc_in   = 1'b1;
        read    = 1'b1;
        mdr_in  = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        bus_en  = 1'b1;
        bus_idx = SRC_MDR;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_alu3 || is_muldiv) begin
          bus_en  = 1'b1;
          bus_idx = SEL_W'(rb);
          y_in    = 1'b1;
          state_d = S_T4;
        end else if (is_halt) begin
          state_d = S_HALTED;
        end else begin
          if (is_mfhi || is_mflo) begin
            bus_en  = 1'b1;
            bus_idx = is_mfhi ? SRC_HI : SRC_LO;
            reg_en  = 1'b1;
          end else if (!is_nop) begin
            illegal = 1'b1;
          end
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        bus_en  = 1'b1;
        bus_idx = SEL_W'(rc);
        z_in    = 1'b1;
        alu_op  = op;
        state_d = S_T5;
      end
      S_T5: begin
        bus_en  = 1'b1;
        bus_idx = SRC_ZL;
        if (is_muldiv) begin
          lo_in   = 1'b1;
          state_d = S_T6;
        end else begin
          reg_en  = 1'b1;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        bus_en  = 1'b1;
        bus_idx = SRC_ZH;
        hi_in   = 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end
      S_HALTED: begin
        done = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // a single index per cycle keeps both select vectors one-hot or empty
  assign bus_src = bus_en ? (BUS_W'(1) << bus_idx) : '0;
  assign reg_in  = reg_en ? (GPR_N'(1) << ra) : '0;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Randomized self-checking bench for bus_control_sequencer against a per-cycle
// expected-output list built from the instruction-class step tables.
module tb_bus_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [23:0] bus_src;
  logic [15:0] reg_in;
  logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
  logic [4:0]  alu_op;
  logic        done, illegal;

  bus_control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_src(bus_src), .reg_in(reg_in), .pc_in(pc_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in),
    .lo_in(lo_in), .inc_pc(inc_pc), .read(read), .alu_op(alu_op), .done(done),
    .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [23:0] bus;
    logic [15:0] regs;
    logic [9:0]  strb;   // pc,mar,mdr,ir,y,z,hi,lo,inc_pc,read
    logic [4:0]  alu;
    logic        dn;
    logic        il;
  } out_t;

  typedef struct packed {
    out_t        o;
    logic        run;
    logic        mr;
    logic        ld;
    logic [31:0] irv;
  } exp_t;

  localparam logic [9:0] ST_PC  = 10'b10_0000_0000;
  localparam logic [9:0] ST_MAR = 10'b01_0000_0000;
  localparam logic [9:0] ST_MDR = 10'b00_1000_0000;
  localparam logic [9:0] ST_IR  = 10'b00_0100_0000;
  localparam logic [9:0] ST_Y   = 10'b00_0010_0000;
  localparam logic [9:0] ST_Z   = 10'b00_0001_0000;
  localparam logic [9:0] ST_HI  = 10'b00_0000_1000;
  localparam logic [9:0] ST_LO  = 10'b00_0000_0100;
  localparam logic [9:0] ST_INC = 10'b00_0000_0010;
  localparam logic [9:0] ST_RD  = 10'b00_0000_0001;

  localparam logic [31:0] W_ADD  = 32'h0189_0000;
  localparam logic [31:0] W_MUL  = 32'h7022_8000;
  localparam logic [31:0] W_MFHI = 32'hC380_0000;
  localparam logic [31:0] W_HALT = 32'hD800_0000;
  localparam logic [31:0] W_ILL  = 32'hA800_0000;

  out_t cur;
  assign cur = {bus_src, reg_in, pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
                inc_pc, read, alu_op, done, illegal};

  exp_t q[$];
  out_t eo[$];
  out_t obs[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [23:0] bs(input int i);
    return 24'(1) << i;
  endfunction

  function automatic logic [15:0] rs(input int i);
    return 16'(1) << i;
  endfunction

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic out_t mk(input logic [23:0] b, input logic [15:0] r, input logic [9:0] s,
                              input logic [4:0] a, input logic dn, input logic il);
    return {b, r, s, a, dn, il};
  endfunction

  task automatic push(input out_t o, input logic rn, input logic m, input logic ld,
                      input logic [31:0] iv);
    exp_t e;
    e.o = o; e.run = rn; e.mr = m; e.ld = ld; e.irv = iv;
    q.push_back(e);
  endtask

  task automatic add_idle(input logic rn);
    push(mk(24'h0, 16'h0, 10'h0, 5'h0, 1'b0, 1'b0), rn, coin(), 1'b0, 32'h0);
  endtask

  task automatic add_halted(input int n);
    for (int i = 0; i < n; i++)
      push(mk(24'h0, 16'h0, 10'h0, 5'h0, 1'b1, 1'b0), coin(), coin(), 1'b0, 32'h0);
  endtask

  // Expected cycles of one instruction; ir is scrambled in T0 and loaded on entering T3.
  task automatic add_instr(input logic [31:0] w, input int stalls, input logic run_after);
    logic [4:0] op;
    int a, b, c;
    op = w[31:27];
    a = int'(w[26:23]);
    b = int'(w[22:19]);
    c = int'(w[18:15]);
    push(mk(bs(20), 16'h0, ST_MAR | ST_INC | ST_Z, 5'h1f, 1'b0, 1'b0), coin(), coin(), 1'b1,
         $urandom);
    for (int i = 0; i <= stalls; i++)
      push(mk(bs(19), 16'h0, ST_PC | ST_RD | ST_MDR, 5'h0, 1'b0, 1'b0), coin(), (i == stalls),
           1'b0, 32'h0);
    push(mk(bs(21), 16'h0, ST_IR, 5'h0, 1'b0, 1'b0), coin(), coin(), 1'b0, 32'h0);
    if (op <= 5'd5 || op == 5'd14 || op == 5'd15) begin
      push(mk(bs(b), 16'h0, ST_Y, 5'h0, 1'b0, 1'b0), coin(), coin(), 1'b1, w);
      push(mk(bs(c), 16'h0, ST_Z, op, 1'b0, 1'b0), coin(), coin(), 1'b0, w);
      if (op <= 5'd5) begin
        push(mk(bs(19), rs(a), 10'h0, 5'h0, 1'b0, 1'b0), run_after, coin(), 1'b0, w);
      end else begin
        push(mk(bs(19), 16'h0, ST_LO, 5'h0, 1'b0, 1'b0), coin(), coin(), 1'b0, w);
        push(mk(bs(18), 16'h0, ST_HI, 5'h0, 1'b0, 1'b0), run_after, coin(), 1'b0, w);
      end
    end else if (op == 5'd24) begin
      push(mk(bs(16), rs(a), 10'h0, 5'h0, 1'b0, 1'b0), run_after, coin(), 1'b1, w);
    end else if (op == 5'd25) begin
      push(mk(bs(17), rs(a), 10'h0, 5'h0, 1'b0, 1'b0), run_after, coin(), 1'b1, w);
    end else if (op == 5'd27) begin
      push(mk(24'h0, 16'h0, 10'h0, 5'h0, 1'b0, 1'b0), coin(), coin(), 1'b1, w);
    end else begin
      push(mk(24'h0, 16'h0, 10'h0, 5'h0, 1'b0, op != 5'd26), run_after, coin(), 1'b1, w);
    end
  endtask

  task automatic run_q(input int limit);
    exp_t e;
    eo.delete();
    obs.delete();
    for (int k = 0; k < limit; k++) begin
      e = q.pop_front();
      @(posedge clock); #1;
      run = e.run;
      mem_ready = e.mr;
      if (e.ld) ir = e.irv;
      @(negedge clock);
      eo.push_back(e.o);
      obs.push_back(cur);
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    run = 1'b1;
    mem_ready = coin();
    for (int i = 0; i < 4; i++) begin
      ir = $urandom;
      @(negedge clock);
      total++;
      if (cur !== '0) begin
        bad++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, cur);
      end
      total++;
      if ($countones(bus_src) > 1 || $countones(reg_in) > 1) begin
        bad++; $display("FAIL reset_onehot bus=%h reg=%h", bus_src, reg_in);
      end
      @(posedge clock); #1;
    end
    reset_n = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_async_reset();
    q.delete();
    add_idle(1'b1);
    add_instr(W_ADD, 0, 1'b1);
    run_q(6);
    q.delete();
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL async_pre cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (cur !== '0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", cur);
    end
    test_reset();
  endtask

  task automatic test_add();
    logic [23:0] seq [6];
    seq[0] = bs(20); seq[1] = bs(19); seq[2] = bs(21);
    seq[3] = bs(1);  seq[4] = bs(2);  seq[5] = bs(19);
    q.delete();
    add_idle(1'b1);
    add_instr(W_ADD, 0, 1'b0);
    add_idle(1'b0);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL add cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL add_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs[k+1].bus !== seq[k]) begin
        bad++; $display("FAIL add_bus cyc=%0d got=%h exp=%h", k + 1, obs[k+1].bus, seq[k]);
      end
    end
    total++;
    if (obs[6].regs !== 16'h0008 || obs[5].regs !== 16'h0 || obs[7].regs !== 16'h0) begin
      bad++; $display("FAIL add_reg_in got=%h/%h/%h exp=0/8/0", obs[5].regs, obs[6].regs,
                      obs[7].regs);
    end
    total++;
    if (obs[5].alu !== 5'h0 || obs[5].strb !== ST_Z) begin
      bad++; $display("FAIL add_alu got=%h strb=%h exp=0", obs[5].alu, obs[5].strb);
    end
  endtask

  task automatic test_stall();
    q.delete();
    add_idle(1'b1);
    add_instr(W_ADD, 3, 1'b0);
    add_idle(1'b0);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL stall_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
    for (int k = 2; k <= 5; k++) begin
      total++;
      if (obs[k].bus !== bs(19) || obs[k].strb !== (ST_PC | ST_RD | ST_MDR)) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h", k, obs[k].bus, obs[k].strb);
      end
    end
    total++;
    if (obs[9].regs !== 16'h0008 || obs[8].regs !== 16'h0) begin
      bad++; $display("FAIL stall_reg_in got=%h/%h exp=0/8", obs[8].regs, obs[9].regs);
    end
  endtask

  task automatic test_mul();
    q.delete();
    add_idle(1'b1);
    add_instr(W_MUL, 0, 1'b0);
    add_idle(1'b0);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL mul cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL mul_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
    total++;
    if (obs[6].bus !== bs(19) || obs[6].strb !== ST_LO) begin
      bad++; $display("FAIL mul_lo got=%h/%h exp=%h/%h", obs[6].bus, obs[6].strb, bs(19), ST_LO);
    end
    total++;
    if (obs[7].bus !== bs(18) || obs[7].strb !== ST_HI) begin
      bad++; $display("FAIL mul_hi got=%h/%h exp=%h/%h", obs[7].bus, obs[7].strb, bs(18), ST_HI);
    end
    total++;
    if (obs[4].bus !== bs(4) || obs[5].bus !== bs(5) || obs[5].alu !== 5'd14) begin
      bad++; $display("FAIL mul_src got=%h/%h alu=%h", obs[4].bus, obs[5].bus, obs[5].alu);
    end
  endtask

  task automatic test_mfhi_halt();
    q.delete();
    add_idle(1'b1);
    add_instr(W_MFHI, 0, 1'b1);
    add_instr(W_HALT, $urandom_range(0, 2), 1'b1);
    add_halted(6);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL mfhi_halt cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL mfhi_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
    total++;
    if (obs[4].bus !== bs(16) || obs[4].regs !== 16'h0080) begin
      bad++; $display("FAIL mfhi got=%h/%h exp=%h/0080", obs[4].bus, obs[4].regs, bs(16));
    end
    total++;
    if (obs[5].bus !== bs(20)) begin
      bad++; $display("FAIL mfhi_next_fetch got=%h exp=%h", obs[5].bus, bs(20));
    end
    total++;
    if (obs[obs.size()-1].dn !== 1'b1) begin
      bad++; $display("FAIL halt_done got=%b exp=1", obs[obs.size()-1].dn);
    end
  endtask

  task automatic test_illegal();
    q.delete();
    add_idle(1'b1);
    add_instr(W_ILL | ($urandom & 32'h07ff_ffff), 0, 1'b1);
    add_instr(W_ADD, 0, 1'b0);
    add_idle(1'b0);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL illegal_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
    total++;
    if (obs[4].il !== 1'b1 || obs[3].il !== 1'b0 || obs[5].il !== 1'b0 ||
        obs[4].regs !== 16'h0) begin
      bad++; $display("FAIL illegal_pulse got=%b%b%b reg=%h exp=010/0", obs[3].il, obs[4].il,
                      obs[5].il, obs[4].regs);
    end
    total++;
    if (obs[5].bus !== bs(20)) begin
      bad++; $display("FAIL illegal_next_fetch got=%h exp=%h", obs[5].bus, bs(20));
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    logic       r;
    q.delete();
    add_idle(1'b1);
    for (int n = 0; n < 30; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      r = (n == 29) ? 1'b0 : ($urandom_range(0, 3) != 0);
      add_instr({op, 27'($urandom)}, $urandom_range(0, 3), r);
      if (!r && n != 29) begin
        add_idle(1'b0);
        add_idle(1'b1);
      end
    end
    add_idle(1'b0);
    run_q(q.size());
    foreach (obs[i]) begin
      total++;
      if (obs[i] !== eo[i]) begin
        bad++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs[i], eo[i]);
      end
      total++;
      if ($countones(obs[i].bus) > 1 || $countones(obs[i].regs) > 1) begin
        bad++; $display("FAIL b2b_onehot cyc=%0d bus=%h reg=%h", i, obs[i].bus, obs[i].regs);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    run = 1'b0;
    ir = 32'h0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_stall();
    test_mul();
    test_illegal();
    test_async_reset();
    test_mfhi_halt();
    test_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
